// File: rtl/noc_eject_unit_pkg.sv
// Shared packet layout and spike record for the NoC local ejection stage.
// Field offsets describe the 32-bit router packet; spike_t is what the buffer stores.
package noc_eject_unit_pkg;

  localparam int COORD_W     = 4;
  localparam int NEURON_ID_W = 16;
  localparam int PKT_W       = 32;

  localparam int DST_X_MSB   = 31;
  localparam int DST_X_LSB   = 28;
  localparam int DST_Y_MSB   = 27;
  localparam int DST_Y_LSB   = 24;
  localparam int SRC_X_MSB   = 23;
  localparam int SRC_X_LSB   = 20;
  localparam int SRC_Y_MSB   = 19;
  localparam int SRC_Y_LSB   = 16;
  localparam int NEURON_MSB  = 15;
  localparam int NEURON_LSB  = 0;

  localparam int SPIKE_W     = 2 * COORD_W + NEURON_ID_W;

  typedef struct packed {
    logic [COORD_W-1:0]     src_x;
    logic [COORD_W-1:0]     src_y;
    logic [NEURON_ID_W-1:0] neuron_id;
  } spike_t;

  function automatic spike_t pkt_to_spike(input logic [PKT_W-1:0] pkt);
    spike_t s;
    s.src_x     = pkt[SRC_X_MSB:SRC_X_LSB];
    s.src_y     = pkt[SRC_Y_MSB:SRC_Y_LSB];
    s.neuron_id = pkt[NEURON_MSB:NEURON_LSB];
    return s;
  endfunction

  function automatic logic dst_match(input logic [PKT_W-1:0]   pkt,
                                     input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return (pkt[DST_X_MSB:DST_X_LSB] == x) && (pkt[DST_Y_MSB:DST_Y_LSB] == y);
  endfunction

endpackage

// File: rtl/noc_eject_unit_eject_fifo.sv
// First-word-fall-through spike buffer with a registered head; capacity counts the
// presented entry. Pointers carry a wrap bit so full/empty need no separate counter.
module eject_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [WIDTH-1:0] data_r;
  logic [PTR_W:0]   wr_ptr_nxt_s;
  logic [PTR_W:0]   rd_ptr_nxt_s;
  logic [WIDTH-1:0] head_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign push_s  = wr_en && !full_s;
  assign pop_s   = rd_en && !empty_s;

  // Next pointers and the entry that will sit at the head after this edge
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = data_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // A write landing on the new head slot bypasses the array
    if (push_s && (rd_ptr_nxt_s[PTR_W-1:0] == wr_ptr_r[PTR_W-1:0])) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[PTR_W-1:0]];
    end
  end

  // Pointer and head register update; reset flushes the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      data_r   <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (wr_ptr_nxt_s != rd_ptr_nxt_s) begin
        data_r <= head_nxt_s;
      end
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data    = data_r;
  assign full       = full_s;
  assign empty      = empty_s;
  assign free_count = DEPTH_CNT - (wr_ptr_r - rd_ptr_r);

endmodule

// File: rtl/noc_eject_unit.sv
// Local ejection stage: destination check, spike decode, buffering toward the neuron
// core, and receive/drop/misroute statistics.
module noc_eject_unit
  import noc_eject_unit_pkg::*;
#(
  parameter logic [COORD_W-1:0] ROUTER_X   = 4'd0,
  parameter logic [COORD_W-1:0] ROUTER_Y   = 4'd0,
  parameter int                 FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PKT_W-1:0]       in_packet,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   spike_valid,
  input  logic                   spike_ready,
  output logic [NEURON_ID_W-1:0] spike_neuron_id,
  output logic [COORD_W-1:0]     spike_src_x,
  output logic [COORD_W-1:0]     spike_src_y,
  input  logic                   clr_stats,
  output logic [15:0]            rx_count,
  output logic [7:0]             drop_count,
  output logic                   misroute_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  spike_t           in_spike_s;
  spike_t           head_spike_s;
  logic             match_s;
  logic             accept_s;
  logic             drop_s;
  logic             misroute_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] free_s;
  logic [15:0]      rx_count_r;
  logic [7:0]       drop_count_r;
  logic             misroute_r;

  assign in_spike_s = pkt_to_spike(in_packet);
  assign match_s    = dst_match(in_packet, ROUTER_X, ROUTER_Y);
  // Full is the pre-pop state, so a push into a full buffer drops even with a pop
  assign accept_s   = in_valid && match_s && !fifo_full_s;
  assign drop_s     = in_valid && match_s && fifo_full_s;
  assign misroute_s = in_valid && !match_s;

  eject_fifo #(
    .WIDTH (SPIKE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept_s),
    .wr_data    (in_spike_s),
    .rd_en      (spike_ready),
    .rd_data    (head_spike_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .free_count (free_s)
  );

  // Statistics; a clear pulse overrides any same-cycle update
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      rx_count_r   <= 16'd0;
      drop_count_r <= 8'd0;
      misroute_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        rx_count_r <= rx_count_r + 16'd1;
      end
      if (drop_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
      if (misroute_s) begin
        misroute_r <= 1'b1;
      end
    end
  end

  // Upstream commits a cycle ahead, so keep one spare slot beyond the next write
  assign in_ready        = (free_s >= CNT_W'(2));
  assign spike_valid     = !fifo_empty_s;
  assign spike_neuron_id = head_spike_s.neuron_id;
  assign spike_src_x     = head_spike_s.src_x;
  assign spike_src_y     = head_spike_s.src_y;
  assign rx_count        = rx_count_r;
  assign drop_count      = drop_count_r;
  assign misroute_err    = misroute_r;

endmodule

// File: tb/tb_noc_eject_unit.sv
// Directed bench for noc_eject_unit at router (2,3) with an 8-entry buffer.
module tb_noc_eject_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_packet;
  logic        in_valid;
  logic        in_ready;
  logic        spike_valid;
  logic        spike_ready;
  logic [15:0] spike_neuron_id;
  logic [3:0]  spike_src_x;
  logic [3:0]  spike_src_y;
  logic        clr_stats;
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
  logic        misroute_err;

  int n_cmp = 0;
  int n_err = 0;

  noc_eject_unit #(
    .ROUTER_X   (4'd2),
    .ROUTER_Y   (4'd3),
    .FIFO_DEPTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_packet       (in_packet),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .spike_valid     (spike_valid),
    .spike_ready     (spike_ready),
    .spike_neuron_id (spike_neuron_id),
    .spike_src_x     (spike_src_x),
    .spike_src_y     (spike_src_y),
    .clr_stats       (clr_stats),
    .rx_count        (rx_count),
    .drop_count      (drop_count),
    .misroute_err    (misroute_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pkt);
    in_packet = pkt;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_packet = 32'h0; in_valid = 1'b0; spike_ready = 1'b0; clr_stats = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, spike_valid}, 32'd0);
    check("rst_rx", {16'd0, rx_count}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_mis", {31'd0, misroute_err}, 32'd0);
    check("rst_id", {16'd0, spike_neuron_id}, 32'd0);

    // 2: single spike
    spike_ready = 1'b1;
    send(32'h231500A7);
    check("t2_valid", {31'd0, spike_valid}, 32'd1);
    check("t2_id", {16'd0, spike_neuron_id}, 32'h00A7);
    check("t2_srcx", {28'd0, spike_src_x}, 32'd1);
    check("t2_srcy", {28'd0, spike_src_y}, 32'd5);
    check("t2_rx", {16'd0, rx_count}, 32'd1);
    tick();
    check("t2_popped", {31'd0, spike_valid}, 32'd0);

    // 3: fill, overflow, drain
    spike_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send({8'h23, 4'(i), 4'h0, 16'h0100 + 16'(i)});
      check("t3_ready", {31'd0, in_ready}, (i + 1 <= 6) ? 32'd1 : 32'd0);
    end
    check("t3_rx", {16'd0, rx_count}, 32'd9);
    send(32'h23000999);
    send(32'h2300099A);
    check("t3_drop", {24'd0, drop_count}, 32'd2);
    check("t3_rx_hold", {16'd0, rx_count}, 32'd9);
    spike_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("t3_dv", {31'd0, spike_valid}, 32'd1);
      check("t3_did", {16'd0, spike_neuron_id}, 32'h0100 + 32'(j));
      check("t3_dsx", {28'd0, spike_src_x}, 32'(j));
      tick();
    end
    check("t3_empty", {31'd0, spike_valid}, 32'd0);
    check("t3_ready_back", {31'd0, in_ready}, 32'd1);

    // 4: misroute
    send(32'h33000001);
    check("t4_valid", {31'd0, spike_valid}, 32'd0);
    check("t4_mis", {31'd0, misroute_err}, 32'd1);
    check("t4_rx", {16'd0, rx_count}, 32'd9);
    tick(); tick();
    check("t4_sticky", {31'd0, misroute_err}, 32'd1);

    // 5: push+pop at 7 entries, then clear with a concurrent accept
    spike_ready = 1'b0;
    for (int i = 0; i < 7; i++) send({8'h23, 8'h00, 16'h0200 + 16'(i)});
    check("t5_ready7", {31'd0, in_ready}, 32'd0);
    spike_ready = 1'b1;
    send(32'h23000207);
    spike_ready = 1'b0;
    check("t5_occ_ready", {31'd0, in_ready}, 32'd0);
    check("t5_head", {16'd0, spike_neuron_id}, 32'h0201);
    check("t5_rx", {16'd0, rx_count}, 32'd17);
    clr_stats = 1'b1;
    send(32'h23000208);
    clr_stats = 1'b0;
    check("t5_clr_rx", {16'd0, rx_count}, 32'd0);
    check("t5_clr_drop", {24'd0, drop_count}, 32'd0);
    check("t5_clr_mis", {31'd0, misroute_err}, 32'd0);
    spike_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("t5_did", {16'd0, spike_neuron_id}, 32'h0201 + 32'(j));
      tick();
    end
    check("t5_empty", {31'd0, spike_valid}, 32'd0);

    // 6: reset with queued spikes, then saturating drops
    spike_ready = 1'b0;
    for (int i = 0; i < 5; i++) send({8'h23, 8'h44, 16'h0300 + 16'(i)});
    check("t6_queued", {31'd0, spike_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", {31'd0, spike_valid}, 32'd0);
    check("t6_ready", {31'd0, in_ready}, 32'd1);
    check("t6_rx", {16'd0, rx_count}, 32'd0);
    for (int i = 0; i < 8; i++) send({8'h23, 8'h00, 16'h0400 + 16'(i)});
    in_packet = 32'h23000500;
    in_valid  = 1'b1;
    for (int k = 0; k < 254; k++) tick();
    check("t6_drop254", {24'd0, drop_count}, 32'd254);
    for (int k = 0; k < 46; k++) tick();
    in_valid = 1'b0;
    check("t6_drop_sat", {24'd0, drop_count}, 32'd255);
    check("t6_rx8", {16'd0, rx_count}, 32'd8);
    check("t6_head", {16'd0, spike_neuron_id}, 32'h0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
